uart_tx_arbiter: RTL
====================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares the single UART transmitter between N_REQ byte-stream sources.
//  Sources are the ALU result digit emitter, the RX echo path and the status/error messages.
//  A grant is locked per message: it is held from the first byte until the byte flagged last.
//  Optionally appends CR/LF after each message.
//  Sits between the post-processing stage(s) and uart_tx, using valid/ready on both sides.
// PARAMETERS
//  N_REQ    2  number of requesters (1..8)
//  TERM_EN  1  1: emit 0x0D,0x0A after every message's last byte; 0: no terminator
//  GW       $clog2(N_REQ) min 1  width of grant_id (localparam)
// PORTS
//  clk        in   1        rising-edge clock
//  rst        in   1        asynchronous reset, active-low (0 = reset)
//  req_valid  in   N_REQ    per-source byte valid
//  req_data   in   8*N_REQ  per-source byte; source i occupies bits [8i+7:8i]
//  req_last   in   N_REQ    per-source: current byte ends the message
//  req_ready  out  N_REQ    per-source ready; only granted bit may be 1
//  tx_valid   out  1        byte valid toward uart_tx
//  tx_data    out  8        byte toward uart_tx
//  tx_ready   in   1        uart_tx accepts the byte when 1
//  busy       out  1        1 while state != IDLE or tx_valid = 1
//  grant_id   out  GW       index of the current or last granted source
// BEHAVIOUR
//  Reset values: tx_valid=0, tx_data=0, req_ready=0, busy=0, grant_id=0, state=IDLE, rr_ptr=0.
//  slot_free = ~tx_valid | tx_ready. A single registered output stage is used; there is no other buffering.
//  FSM states: IDLE, PASS, TERM_CR, TERM_LF.
//   IDLE: if any req_valid, pick a winner round-robin, searching from rr_ptr upward with wrap.
//         grant_id <= winner; next state PASS. Arbitration costs 1 cycle. req_ready stays 0 in IDLE.
//   PASS: req_ready[grant_id] = slot_free (combinational). All other req_ready bits are 0.
//         On req handshake: tx_data <= byte, tx_valid <= 1.
//         If req_last=1, then rr_ptr <= grant_id+1 (wraps to 0 at N_REQ).
//         Next state on last: TERM_CR if TERM_EN=1, otherwise IDLE.
//   TERM_CR: when slot_free, tx_data <= 8'h0D, tx_valid <= 1; next state TERM_LF.
//   TERM_LF: when slot_free, tx_data <= 8'h0A, tx_valid <= 1; next state IDLE.
//  tx_valid drops to 0 after a tx handshake if no new byte is loaded in the same cycle.
//  Back-to-back throughput: 1 byte/cycle while tx_ready=1.
//  Latency: a byte accepted at edge n is presented on tx_data from edge n onward.
//  Boundaries:
//   - tx_ready held low: tx_data and tx_valid stay stable; req_ready=0; no byte is lost.
//   - Granted source drops req_valid mid-message: grant is held indefinitely. There is no timeout.
//   - Simultaneous requests: the round-robin order decides. After reset, source 0 has priority.
//   - Single-byte message (valid and last together on the first byte): legal, handled normally.
//   - Non-granted sources' valid, data and last are ignored. Their bytes are never dropped or reordered.
//   - N_REQ=1: the arbiter degenerates to a pass-through with the terminator; grant_id stays 0.
//   - rst asserted mid-message: everything returns to reset values immediately.
//     The partial message is abandoned and no terminator is sent.
//   - TERM_EN=0: PASS goes straight to IDLE on last. One idle cycle is inserted between messages.
// STRUCTURE
//  Shared package uart_pkg holds:
//   - ASCII_CR = 8'h0D and ASCII_LF = 8'h0A
//   - tx_arb_state_t encoding: IDLE=2'd0, PASS=2'd1, TERM_CR=2'd2, TERM_LF=2'd3
//  Sub-module rr_arbiter (combinational): inputs req[N_REQ] and ptr[GW].
//   Outputs any and idx[GW] (first set bit at or after ptr, with wrap).
//  The top level contains the FSM, the output register and the req_ready decode.
// TESTING
//  1. Src0 sends 0x31,0x32,0x33 (last on 0x33), TERM_EN=1, tx_ready=1.
//     -> tx sees 31,32,33,0D,0A; grant_id=0; busy=0 after the 0A handshake.
//  2. Src0 and src1 both valid from reset, each sending 2 bytes.
//     -> src0 message completes with its CR/LF, then src1; src1 is never interleaved into src0's message.
//  3. Repeat 2 with both sources continuously requesting.
//     -> grants alternate 0,1,0,1; rr_ptr wraps correctly.
//  4. tx_ready held 0 for 10 cycles with byte 0x35 loaded.
//     -> tx_data=0x35 stable, req_ready=0, and the next byte appears only after tx_ready=1.
//  5. Src1 single-byte message 0x41 with last=1, TERM_EN=0.
//     -> tx sees only 0x41, then IDLE; grant_id=1.
//  6. rst pulled low after the 2nd byte of a 3-byte message.
//     -> all outputs at reset values; after release, src0 is granted first and no CR/LF is emitted.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: ASCII terminator bytes and the TX arbiter state encoding.
package uart_pkg;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PASS    = 2'd1,
    TERM_CR = 2'd2,
    TERM_LF = 2'd3
  } tx_arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping to 0.
module rr_arbiter #(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned GW    = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [GW-1:0]    ptr,
  output logic             any,
  output logic [GW-1:0]    idx
);

  always_comb begin
    any = 1'b0;
    idx = '0;
    // Upper pass covers [ptr, N_REQ-1]; lower pass supplies the wrapped part [0, ptr-1].
    for (int j = 0; j < int'(N_REQ); j++) begin
      if (!any && req[j] && (j >= int'(ptr))) begin
        any = 1'b1;
        idx = GW'(j);
      end
    end
    for (int j = 0; j < int'(N_REQ); j++) begin
      if (!any && req[j] && (j < int'(ptr))) begin
        any = 1'b1;
        idx = GW'(j);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-locked round-robin arbiter feeding one UART transmitter, with optional CR/LF suffix.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned N_REQ   = 2,
  parameter bit          TERM_EN = 1'b1,
  localparam int unsigned GW     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic               tx_valid,
  output logic [7:0]         tx_data,
  input  logic               tx_ready,
  output logic               busy,
  output logic [GW-1:0]      grant_id
);

  tx_arb_state_t r_state, w_state_d;
  logic          r_tx_valid, w_tx_valid_d;
  logic [7:0]    r_tx_data, w_tx_data_d;
  logic [GW-1:0] r_grant_id, w_grant_id_d;
  logic [GW-1:0] r_rr_ptr, w_rr_ptr_d;

  logic          w_slot_free;
  logic          w_any;
  logic [GW-1:0] w_winner;
  logic          w_sel_valid;
  logic [7:0]    w_sel_data;
  logic          w_sel_last;
  logic          w_req_hs;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .GW    (GW)
  ) u_rr_arbiter (
    .req (req_valid),
    .ptr (r_rr_ptr),
    .any (w_any),
    .idx (w_winner)
  );

  assign w_slot_free = ~r_tx_valid | tx_ready;

  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_data  = '0;
    w_sel_last  = 1'b0;
    req_ready   = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (r_grant_id == GW'(i)) begin
        w_sel_valid  = req_valid[i];
        w_sel_data   = req_data[8*i +: 8];
        w_sel_last   = req_last[i];
        req_ready[i] = (r_state == PASS) && w_slot_free;
      end
    end
  end

  assign w_req_hs = (r_state == PASS) && w_sel_valid && w_slot_free;

  always_comb begin
    w_state_d    = r_state;
    w_tx_valid_d = r_tx_valid & ~tx_ready;
    w_tx_data_d  = r_tx_data;
    w_grant_id_d = r_grant_id;
    w_rr_ptr_d   = r_rr_ptr;
    unique case (r_state)
      IDLE: begin
        if (w_any) begin
          w_grant_id_d = w_winner;
          w_state_d    = PASS;
        end
      end
      PASS: begin
        if (w_req_hs) begin
          w_tx_data_d  = w_sel_data;
          w_tx_valid_d = 1'b1;
          if (w_sel_last) begin
            w_rr_ptr_d = (r_grant_id == GW'(N_REQ - 1)) ? '0 : r_grant_id + GW'(1);
            w_state_d  = TERM_EN ? TERM_CR : IDLE;
          end
        end
      end
      TERM_CR: begin
        if (w_slot_free) begin
          w_tx_data_d  = ASCII_CR;
          w_tx_valid_d = 1'b1;
          w_state_d    = TERM_LF;
        end
      end
      TERM_LF: begin
        if (w_slot_free) begin
          w_tx_data_d  = ASCII_LF;
          w_tx_valid_d = 1'b1;
          w_state_d    = IDLE;
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_tx_valid <= 1'b0;
      r_tx_data  <= '0;
      r_grant_id <= '0;
      r_rr_ptr   <= '0;
    end else begin
      r_state    <= w_state_d;
      r_tx_valid <= w_tx_valid_d;
      r_tx_data  <= w_tx_data_d;
      r_grant_id <= w_grant_id_d;
      r_rr_ptr   <= w_rr_ptr_d;
    end
  end

  assign tx_valid = r_tx_valid;
  assign tx_data  = r_tx_data;
  assign grant_id = r_grant_id;
  assign busy     = (r_state != IDLE) | r_tx_valid;

endmodule
